store_buffer: RTL

- Posted-write buffer between the CPU memory stage and the data memory.
- Accepts stores from the CPU without waiting and queues them in order.
- Drains queued stores to the data memory whenever its port is idle.
- Loads that hit a queued store are answered from the buffer, youngest entry first.
- The data memory's one-clock registered read timing is kept on the CPU side.

---
 rtl/store_buffer_pkg.sv | 19 +
 rtl/store_buffer_if.sv | 35 +++
 rtl/store_buffer_cam.sv | 31 +++
 rtl/store_buffer.sv | 112 +++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and sizing helpers for the posted-write store buffer.
package store_buffer_pkg;

   localparam int SB_DEPTH  = 4;
   localparam int SB_ADDR_W = 32;
   localparam int SB_DATA_W = 32;

   typedef struct packed {
      logic                 valid;
      logic [SB_ADDR_W-1:0] addr;
      logic [SB_DATA_W-1:0] data;
   } sb_entry_t;

   // Occupancy counter must hold 0..depth inclusive so full and empty differ.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/store_buffer_if.sv
// CPU-side load/store port and data-memory port of the store buffer.
interface store_buffer_if
   import store_buffer_pkg::*;
#(
   parameter int ADDR_W = SB_ADDR_W,
   parameter int DATA_W = SB_DATA_W
);

   logic              in_ctrl_read;
   logic              in_ctrl_write;
   logic [ADDR_W-1:0] in_addr;
   logic [DATA_W-1:0] in_data;
   logic [DATA_W-1:0] out_data;
   logic              out_data_valid;
   logic              out_stall;
   logic              out_empty;
   logic              out_mem_read;
   logic              out_mem_write;
   logic [ADDR_W-1:0] out_mem_addr;
   logic [DATA_W-1:0] out_mem_data;
   logic [DATA_W-1:0] in_mem_data;

   modport slave (
      input  in_ctrl_read, in_ctrl_write, in_addr, in_data, in_mem_data,
      output out_data, out_data_valid, out_stall, out_empty,
             out_mem_read, out_mem_write, out_mem_addr, out_mem_data
   );

   modport master (
      output in_ctrl_read, in_ctrl_write, in_addr, in_data, in_mem_data,
      input  out_data, out_data_valid, out_stall, out_empty,
             out_mem_read, out_mem_write, out_mem_addr, out_mem_data
   );

endinterface

// File: rtl/store_buffer_cam.sv
// Youngest-first address match over the queued store entries.
module store_buffer_cam
   import store_buffer_pkg::*;
#(
   parameter  int DEPTH = SB_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = cnt_width(DEPTH)
) (
   input  sb_entry_t            entries [DEPTH],
   input  logic [PTR_W-1:0]     head,
   input  logic [CNT_W-1:0]     count,
   input  logic [SB_ADDR_W-1:0] in_addr,
   output logic                 hit,
   output logic [SB_DATA_W-1:0] hit_data
);

   // Walk oldest to youngest so a later match overrides an earlier one.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(i) < count) &&
             entries[head + PTR_W'(i)].valid &&
             (entries[head + PTR_W'(i)].addr == in_addr)) begin
            hit      = 1'b1;
            hit_data = entries[head + PTR_W'(i)].data;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer: queues CPU stores, drains them when the memory port
// is idle, and forwards queued data to loads that hit.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH  = SB_DEPTH,
   parameter int ADDR_W = SB_ADDR_W,
   parameter int DATA_W = SB_DATA_W
) (
   input logic           clk,
   input logic           in_rst_n,
   store_buffer_if.slave bus
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam int               CNT_W    = cnt_width(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   sb_entry_t         entries [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;

   logic              hit;
   logic [DATA_W-1:0] hit_data;
   logic [ADDR_W-1:0] head_addr;
   logic              rd_en;
   logic              miss;
   logic              full;
   logic              accept;
   logic              drain;

   logic              rd_valid_q;
   logic              sel_hit_q;
   logic [DATA_W-1:0] hit_data_q;
   logic [DATA_W-1:0] hold_q;
   logic [DATA_W-1:0] rd_data;

   store_buffer_cam #(.DEPTH(DEPTH)) u_cam (
      .entries  (entries),
      .head     (head),
      .count    (count),
      .in_addr  (bus.in_addr),
      .hit      (hit),
      .hit_data (hit_data)
   );

   // Loads are masked during reset so no memory read escapes while held.
   assign rd_en  = bus.in_ctrl_read & in_rst_n;
   assign miss   = rd_en & ~hit;
   assign full   = (count == FULL_CNT);
   assign accept = bus.in_ctrl_write & ~bus.in_ctrl_read & ~full;
   assign drain  = ~miss & (count != '0);

   assign head_addr = entries[head].addr;

   assign bus.out_stall     = bus.in_ctrl_write & (bus.in_ctrl_read | full);
   assign bus.out_empty     = (count == '0);
   assign bus.out_mem_read  = miss;
   assign bus.out_mem_write = drain;
   assign bus.out_mem_addr  = miss ? bus.in_addr : head_addr;
   assign bus.out_mem_data  = entries[head].data;

   always_ff @(posedge clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else begin
         // Full check uses the pre-drain count, so a same-cycle pop never
         // lets a store in while the buffer reads as full.
         if (accept) begin
            entries[tail] <= '{valid: 1'b1, addr: bus.in_addr, data: bus.in_data};
            tail          <= tail + 1'b1;
         end
         if (drain) begin
            entries[head].valid <= 1'b0;
            head                <= head + 1'b1;
         end
         count <= count + CNT_W'(accept) - CNT_W'(drain);
      end
   end

   always_ff @(posedge clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         rd_valid_q <= 1'b0;
         sel_hit_q  <= 1'b0;
         hit_data_q <= '0;
         hold_q     <= '0;
      end else begin
         rd_valid_q <= rd_en;
         if (rd_en) begin
            sel_hit_q <= hit;
         end
         if (rd_en && hit) begin
            hit_data_q <= hit_data;
         end
         if (rd_valid_q) begin
            hold_q <= rd_data;
         end
      end
   end

   // Memory read data arrives one clock late, aligned with rd_valid_q.
   assign rd_data            = sel_hit_q ? hit_data_q : bus.in_mem_data;
   assign bus.out_data       = rd_valid_q ? rd_data : hold_q;
   assign bus.out_data_valid = rd_valid_q;

endmodule
